// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: merges WB and dcache miss-return writes onto the regfile port, tracks pending misses.
// Optional conflict statistics are built only when RFARB_STATS_EN is defined.
module regfile_wr_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int QDEPTH = 2,
  parameter int STARVE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_we,
  input  logic [AW-1:0]        pipe_wa,
  input  logic [DW-1:0]        pipe_wd,
  input  logic                 mem_valid,
  input  logic [AW-1:0]        mem_wa,
  input  logic [DW-1:0]        mem_wd,
  output logic                 mem_ready,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_wa,
  input  logic [AW-1:0]        chk_ra1,
  input  logic [AW-1:0]        chk_ra2,
  input  logic [AW-1:0]        chk_wa,
  output logic                 stall,
  output logic                 pipe_hold,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic [(1<<AW)-1:0]   pend_vec,
  output logic [15:0]          stat_conf
);
  localparam int NR = 1 << AW;
  localparam int PW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE + 1);

  logic [AW-1:0] q_wa [QDEPTH];
  logic [DW-1:0] q_wd [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt, cnt_nxt;
  logic          full, empty, pipe_req, pop, push;
  logic [SW-1:0] wait_cnt;
  logic [NR-1:0] pend, pend_nxt;

  assign pipe_req = pipe_we & (|pipe_wa);
  assign empty    = cnt == '0;
  assign pop      = !pipe_req & !empty;
  assign push     = mem_valid & mem_ready & (|mem_wa);
  assign cnt_nxt  = cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  // full is registered so acceptance never depends on a same-cycle pop
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      rd_ptr <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr <= push ? wr_ptr + PW'(1) : wr_ptr;
      cnt    <= cnt_nxt;
      full   <= cnt_nxt == (PW+1)'(QDEPTH);
    end

  always_ff @(posedge clk)
    if (push) begin
      q_wa[wr_ptr] <= mem_wa;
      q_wd[wr_ptr] <= mem_wd;
    end

  always_comb begin
    pend_nxt = pend;
    if (pop) pend_nxt[q_wa[rd_ptr]] = 1'b0;
    if (pend_set && |pend_wa) pend_nxt[pend_wa] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) pend <= '0;
    else pend <= pend_nxt;

  always_ff @(posedge clk or posedge rst)
    if (rst) wait_cnt <= '0;
    else if (pop) wait_cnt <= '0;
    else if (!empty && wait_cnt != SW'(STARVE)) wait_cnt <= wait_cnt + SW'(1);

  assign pend_vec  = pend;
  assign mem_ready = !rst & !full;
  assign stall     = !rst & (pend[chk_ra1] | pend[chk_ra2] | pend[chk_wa]);
  assign pipe_hold = !rst & (wait_cnt >= SW'(STARVE));
  assign rf_we     = !rst & (pipe_req | !empty);
  assign rf_wa     = rst ? '0 : pipe_req ? pipe_wa : !empty ? q_wa[rd_ptr] : '0;
  assign rf_wd     = rst ? '0 : pipe_req ? pipe_wd : !empty ? q_wd[rd_ptr] : '0;

`ifdef RFARB_STATS_EN
  logic [15:0] conf;
  always_ff @(posedge clk or posedge rst)
    if (rst) conf <= '0;
    else if (pipe_req && !empty && conf != 16'hFFFF) conf <= conf + 16'd1;
  assign stat_conf = conf;
`else
  assign stat_conf = 16'h0000;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus checked each cycle against a queue-based model of the arbiter.
module tb_regfile_wr_arbiter;
  localparam int QDEPTH = 2;
  localparam int STARVE = 4;
`ifdef RFARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 0, rst = 1;
  logic pipe_we, mem_valid, pend_set;
  logic [4:0] pipe_wa, mem_wa, pend_wa, chk_ra1, chk_ra2, chk_wa;
  logic [31:0] pipe_wd, mem_wd;
  logic mem_ready, stall, pipe_hold, rf_we;
  logic [4:0] rf_wa;
  logic [31:0] rf_wd, pend_vec;
  logic [15:0] stat_conf;

  regfile_wr_arbiter #(.DW(32), .AW(5), .QDEPTH(QDEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst), .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
    .mem_valid(mem_valid), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .pend_set(pend_set), .pend_wa(pend_wa), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
    .chk_wa(chk_wa), .stall(stall), .pipe_hold(pipe_hold), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .pend_vec(pend_vec), .stat_conf(stat_conf)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {logic [4:0] wa; logic [31:0] wd;} ent_t;
  ent_t mq[$];
  bit [31:0] mpend;
  int mwait, mstat;
  bit preq, has, e_ready, e_stall;
  logic [4:0] e_wa;
  logic [31:0] e_wd;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mpend = 0;
      mwait = 0;
      mstat = 0;
      chk("rst_rf_we", 64'(rf_we), 0);
      chk("rst_mem_ready", 64'(mem_ready), 0);
      chk("rst_stall", 64'(stall), 0);
      chk("rst_pipe_hold", 64'(pipe_hold), 0);
      chk("rst_pend_vec", 64'(pend_vec), 0);
      chk("rst_stat_conf", 64'(stat_conf), 0);
    end else begin
      preq = pipe_we && pipe_wa != 0;
      has = mq.size() != 0;
      e_wa = preq ? pipe_wa : has ? mq[0].wa : 5'd0;
      e_wd = preq ? pipe_wd : has ? mq[0].wd : 32'd0;
      e_ready = mq.size() < QDEPTH;
      e_stall = (chk_ra1 != 0 && mpend[chk_ra1]) || (chk_ra2 != 0 && mpend[chk_ra2]) ||
                (chk_wa != 0 && mpend[chk_wa]);
      chk("rf_we", 64'(rf_we), 64'(preq || has));
      chk("rf_wa", 64'(rf_wa), 64'(e_wa));
      chk("rf_wd", 64'(rf_wd), 64'(e_wd));
      chk("mem_ready", 64'(mem_ready), 64'(e_ready));
      chk("stall", 64'(stall), 64'(e_stall));
      chk("pipe_hold", 64'(pipe_hold), 64'(mwait >= STARVE));
      chk("pend_vec", 64'(pend_vec), 64'(mpend));
      chk("stat_conf", 64'(stat_conf), STATS ? 64'(mstat) : 64'd0);
      if (!preq && has) begin
        mpend[mq[0].wa] = 1'b0;
        void'(mq.pop_front());
        mwait = 0;
      end else if (has && mwait < STARVE) mwait++;
      if (mem_valid && e_ready && mem_wa != 0) mq.push_back('{mem_wa, mem_wd});
      if (pend_set && pend_wa != 0) mpend[pend_wa] = 1'b1;
      if (preq && has && mstat < 65535) mstat++;
    end
  end

  task automatic clr();
    pipe_we = 0; pipe_wa = 0; pipe_wd = 0;
    mem_valid = 0; mem_wa = 0; mem_wd = 0;
    pend_set = 0; pend_wa = 0;
    chk_ra1 = 0; chk_ra2 = 0; chk_wa = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset dominates active requests
    clr();
    mem_valid = 1; mem_wa = 4; pipe_we = 1; pipe_wa = 2; pend_set = 1; pend_wa = 6; chk_wa = 6;
    @(negedge clk);
    chk("t1_rf_we", 64'(rf_we), 0);
    chk("t1_mem_ready", 64'(mem_ready), 0);
    chk("t1_stall", 64'(stall), 0);
    nxt(); clr(); rst = 0;
    @(negedge clk);
    chk("t1_pend_vec", 64'(pend_vec), 0);
    nxt();
    // T2: pipe wins, queued return follows next cycle and clears its pending bit
    pend_set = 1; pend_wa = 5;
    @(negedge clk);
    nxt(); clr();
    pipe_we = 1; pipe_wa = 3; pipe_wd = 32'hAA; mem_valid = 1; mem_wa = 5; mem_wd = 32'hBB;
    @(negedge clk);
    chk("t2_wa_pipe", 64'(rf_wa), 3);
    chk("t2_wd_pipe", 64'(rf_wd), 32'hAA);
    nxt(); clr();
    @(negedge clk);
    chk("t2_we_q", 64'(rf_we), 1);
    chk("t2_wa_q", 64'(rf_wa), 5);
    chk("t2_wd_q", 64'(rf_wd), 32'hBB);
    chk("t2_pend5_set", 64'(pend_vec[5]), 1);
    nxt();
    @(negedge clk);
    chk("t2_idle_we", 64'(rf_we), 0);
    chk("t2_pend_clr", 64'(pend_vec), 0);
    nxt();
    // T3: stall on pending r7 until the cycle after its pop
    pend_set = 1; pend_wa = 7; chk_ra2 = 7;
    @(negedge clk);
    chk("t3_stall_pre", 64'(stall), 0);
    nxt();
    pend_set = 0; mem_valid = 1; mem_wa = 7; mem_wd = 32'h77;
    @(negedge clk);
    chk("t3_stall", 64'(stall), 1);
    nxt();
    mem_valid = 0;
    @(negedge clk);
    chk("t3_stall_pop", 64'(stall), 1);
    chk("t3_wa_pop", 64'(rf_wa), 7);
    nxt();
    @(negedge clk);
    chk("t3_stall_after", 64'(stall), 0);
    nxt(); clr();
    // T4: fill queue while pipe busy, starve, then drain
    pipe_we = 1; pipe_wa = 1; pipe_wd = 1; mem_valid = 1; mem_wa = 10; mem_wd = 32'hA0;
    @(negedge clk); nxt();
    pipe_wa = 2; mem_wa = 11; mem_wd = 32'hB0;
    @(negedge clk); nxt();
    mem_wa = 12; mem_wd = 32'hC0;
    @(negedge clk);
    chk("t4_full", 64'(mem_ready), 0);
    nxt(); mem_valid = 0;
    @(negedge clk); nxt();
    @(negedge clk);
    chk("t4_no_hold_yet", 64'(pipe_hold), 0);
    nxt();
    pipe_we = 0;
    @(negedge clk);
    chk("t4_hold", 64'(pipe_hold), 1);
    chk("t4_wa_head", 64'(rf_wa), 10);
    nxt();
    @(negedge clk);
    chk("t4_hold_clr", 64'(pipe_hold), 0);
    chk("t4_ready", 64'(mem_ready), 1);
    chk("t4_wa_next", 64'(rf_wa), 11);
    chk("t4_stat", 64'(stat_conf), STATS ? 64'd4 : 64'd0);
    nxt();
    @(negedge clk);
    chk("t4_no_c0", 64'(rf_we), 0);
    nxt(); clr();
    // T5: set wins over same-cycle pop clear
    pend_set = 1; pend_wa = 9; mem_valid = 1; mem_wa = 9; mem_wd = 32'h99;
    @(negedge clk); nxt();
    mem_valid = 0;
    @(negedge clk);
    chk("t5_pop9", 64'(rf_wa), 9);
    nxt(); clr();
    @(negedge clk);
    chk("t5_pend9", 64'(pend_vec[9]), 1);
    chk("t5_we", 64'(rf_we), 0);
    nxt();
    // T6: r0 writes are dropped / not requests
    mem_valid = 1; mem_wa = 0; mem_wd = 32'h55;
    @(negedge clk);
    chk("t6_ready", 64'(mem_ready), 1);
    nxt();
    mem_wa = 13; mem_wd = 32'hD0;
    @(negedge clk);
    chk("t6_r0_dropped", 64'(rf_we), 0);
    nxt(); clr();
    pipe_we = 1; pipe_wa = 0; pipe_wd = 32'hEE;
    @(negedge clk);
    chk("t6_q_wins_wa", 64'(rf_wa), 13);
    chk("t6_q_wins_wd", 64'(rf_wd), 32'hD0);
    nxt(); clr();
    // reset mid-queue discards the queued write
    mem_valid = 1; mem_wa = 14; mem_wd = 32'hE0;
    pipe_we = 1; pipe_wa = 4; pipe_wd = 32'h44;
    @(negedge clk); nxt(); clr();
    rst = 1;
    @(negedge clk); nxt();
    rst = 0;
    @(negedge clk);
    chk("rst_discard_we", 64'(rf_we), 0);
    chk("rst_pend_clr", 64'(pend_vec), 0);
    nxt();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
